// File: rtl/draw_scheduler_if.sv
// ---------------------------------------------------------------------------
// draw_scheduler_if
// Bundle between the gameplay datapath, the draw scheduler and the VGA
// adapter write port.
//   Requests (master -> slave):
//     clr_req, ers_req, drw_req   level requests, held until the matching done
//     ers_x/ers_y, drw_x/drw_y    rectangle top-left corners
//     drw_col                     draw colour
//     vsync                       one-cycle frame-start pulse
//   Responses (slave -> master):
//     clr_done, ers_done, drw_done  one-cycle job-complete pulses
//     busy                          scheduler not idle
//     plot, vga_x, vga_y, vga_col   framebuffer write port
// ---------------------------------------------------------------------------
interface draw_scheduler_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
);
  logic           clr_req;
  logic           ers_req;
  logic [X_W-1:0] ers_x;
  logic [Y_W-1:0] ers_y;
  logic           drw_req;
  logic [X_W-1:0] drw_x;
  logic [Y_W-1:0] drw_y;
  logic [C_W-1:0] drw_col;
  logic           vsync;
  logic           clr_done;
  logic           ers_done;
  logic           drw_done;
  logic           busy;
  logic           plot;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_col;

  modport master (
    output clr_req, ers_req, ers_x, ers_y, drw_req, drw_x, drw_y, drw_col, vsync,
    input  clr_done, ers_done, drw_done, busy, plot, vga_x, vga_y, vga_col
  );

  modport slave (
    input  clr_req, ers_req, ers_x, ers_y, drw_req, drw_x, drw_y, drw_col, vsync,
    output clr_done, ers_done, drw_done, busy, plot, vga_x, vga_y, vga_col
  );
endinterface

// File: rtl/draw_scheduler.sv
// ---------------------------------------------------------------------------
// draw_scheduler
// Arbitrates the single VGA framebuffer write port among full-screen clear,
// erase of the previous block and draw of the current block (fixed priority
// clear > erase > draw). Each granted job is rastered one pixel per cycle,
// off-screen pixels are suppressed, and the requester gets a done pulse
// together with the last pixel.
// Ports:
//   clk     clock
//   resetn  synchronous, active-low reset
//   sched   draw_scheduler_if.slave: requests, coordinates, colour, vsync in;
//           done pulses, busy, plot/vga_x/vga_y/vga_col out (all registered)
// Optional feature: define FRAME_SYNC_EN to start at most one job per frame
// (a grant needs a vsync pulse seen since the previous grant).
// ---------------------------------------------------------------------------
module draw_scheduler #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int C_W    = 3,
  parameter int BLK_W  = 16,
  parameter int BLK_H  = 8,
  parameter int SCR_W  = 160,
  parameter int SCR_H  = 120,
  parameter int BG_COL = 0
) (
  input logic            clk,
  input logic            resetn,
  draw_scheduler_if.slave sched
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLOT = 1'b1;

  localparam logic [1:0] J_CLR = 2'd0;
  localparam logic [1:0] J_ERS = 2'd1;
  localparam logic [1:0] J_DRW = 2'd2;

  localparam logic [X_W:0]   L_SCR_W  = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0]   L_SCR_H  = (Y_W+1)'(SCR_H);
  localparam logic [X_W-1:0] L_CLR_LX = X_W'(SCR_W - 1);
  localparam logic [Y_W-1:0] L_CLR_LY = Y_W'(SCR_H - 1);
  localparam logic [X_W-1:0] L_BLK_LX = X_W'(BLK_W - 1);
  localparam logic [Y_W-1:0] L_BLK_LY = Y_W'(BLK_H - 1);
  localparam logic [C_W-1:0] L_BG     = C_W'(BG_COL);

  logic [0:0]     r_state;
  logic [1:0]     r_job;
  logic [X_W-1:0] r_base_x;
  logic [Y_W-1:0] r_base_y;
  logic [C_W-1:0] r_col;
  logic [X_W-1:0] r_last_x;
  logic [Y_W-1:0] r_last_y;
  logic [X_W-1:0] r_cx;
  logic [Y_W-1:0] r_cy;
  logic           r_busy;
  logic           r_plot;
  logic           r_clr_done;
  logic           r_ers_done;
  logic           r_drw_done;
  logic [X_W-1:0] r_vga_x;
  logic [Y_W-1:0] r_vga_y;
  logic [C_W-1:0] r_vga_col;

  logic           w_grant_ok;
  logic           w_any_req;

  // Clip test works on the unwrapped sums, one bit wider than the coordinates,
  // so a rectangle running off the right/bottom edge never wraps back on-screen.
  function automatic logic on_screen(input logic [X_W-1:0] bx, input logic [X_W-1:0] cx,
                                     input logic [Y_W-1:0] by, input logic [Y_W-1:0] cy);
    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    sx = {1'b0, bx} + {1'b0, cx};
    sy = {1'b0, by} + {1'b0, cy};
    return (sx < L_SCR_W) && (sy < L_SCR_H);
  endfunction

`ifdef FRAME_SYNC_EN
  logic r_vsync_seen;

  // Remembers a frame start until the next grant consumes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vsync_seen <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req && w_grant_ok) begin
      r_vsync_seen <= 1'b0;
    end else if (sched.vsync) begin
      r_vsync_seen <= 1'b1;
    end
  end

  assign w_grant_ok = r_vsync_seen | sched.vsync;
`else
  assign w_grant_ok = 1'b1;
`endif

  assign w_any_req = sched.clr_req | sched.ers_req | sched.drw_req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_job      <= J_CLR;
      r_base_x   <= '0;
      r_base_y   <= '0;
      r_col      <= '0;
      r_last_x   <= '0;
      r_last_y   <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_busy     <= 1'b0;
      r_plot     <= 1'b0;
      r_clr_done <= 1'b0;
      r_ers_done <= 1'b0;
      r_drw_done <= 1'b0;
      r_vga_x    <= '0;
      r_vga_y    <= '0;
      r_vga_col  <= '0;
    end else begin
      r_clr_done <= 1'b0;
      r_ers_done <= 1'b0;
      r_drw_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          // Grant stage: latch the job so the requester may change its inputs freely.
          if (w_any_req && w_grant_ok) begin
            r_state <= S_PLOT;
            r_busy  <= 1'b1;
            r_cx    <= '0;
            r_cy    <= '0;
            if (sched.clr_req) begin
              r_job    <= J_CLR;
              r_base_x <= '0;
              r_base_y <= '0;
              r_col    <= L_BG;
              r_last_x <= L_CLR_LX;
              r_last_y <= L_CLR_LY;
            end else if (sched.ers_req) begin
              r_job    <= J_ERS;
              r_base_x <= sched.ers_x;
              r_base_y <= sched.ers_y;
              r_col    <= L_BG;
              r_last_x <= L_BLK_LX;
              r_last_y <= L_BLK_LY;
            end else begin
              r_job    <= J_DRW;
              r_base_x <= sched.drw_x;
              r_base_y <= sched.drw_y;
              r_col    <= sched.drw_col;
              r_last_x <= L_BLK_LX;
              r_last_y <= L_BLK_LY;
            end
          end
        end
        default: begin
          // Raster stage: emit pixel (cx,cy), then step the counters.
          r_vga_x   <= r_base_x + r_cx;
          r_vga_y   <= r_base_y + r_cy;
          r_vga_col <= r_col;
          r_plot    <= on_screen(r_base_x, r_cx, r_base_y, r_cy);
          if (r_cx == r_last_x) begin
            r_cx <= '0;
            if (r_cy == r_last_y) begin
              r_cy       <= '0;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_clr_done <= (r_job == J_CLR);
              r_ers_done <= (r_job == J_ERS);
              r_drw_done <= (r_job == J_DRW);
            end else begin
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
      endcase
    end
  end

  assign sched.busy     = r_busy;
  assign sched.plot     = r_plot;
  assign sched.clr_done = r_clr_done;
  assign sched.ers_done = r_ers_done;
  assign sched.drw_done = r_drw_done;
  assign sched.vga_x    = r_vga_x;
  assign sched.vga_y    = r_vga_y;
  assign sched.vga_col  = r_vga_col;
endmodule

// File: tb/tb_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_draw_scheduler
// Directed bench for draw_scheduler: reset, single draw, clear/draw priority,
// clipping, reset mid-erase and (with FRAME_SYNC_EN) frame-synchronous grants.
// ---------------------------------------------------------------------------
module tb_draw_scheduler;
  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;
  logic drop_vsync;

  draw_scheduler_if bus ();

  draw_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .sched  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Grants on the next edge, then follows npix pixels against a reference raster.
  // fx/fy and lx/ly are the hand-computed first and last pixel coordinates.
  task automatic run_job(input string tag, input int job, input int bx, input int by,
                         input int col, input int w, input int h, input int npix,
                         input int exp_plots, input int fx, input int fy,
                         input int lx, input int ly);
    int errs, plots, cx, cy, ex, ey;
    logic ep;
    logic [2:0] dn, edn;
    @(posedge clk);
    @(negedge clk);
    if (drop_vsync) bus.vsync = 1'b0;
    chk({tag, "_grant_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_grant_plot"}, 32'(bus.plot), 32'd0);
    errs  = 0;
    plots = 0;
    for (int n = 0; n < npix; n++) begin
      @(posedge clk);
      @(negedge clk);
      cx  = n % w;
      cy  = n / w;
      ex  = (bx + cx) % 256;
      ey  = (by + cy) % 128;
      ep  = ((bx + cx) < 160) && ((by + cy) < 120);
      dn  = {bus.drw_done, bus.ers_done, bus.clr_done};
      edn = (n == w * h - 1) ? (3'b001 << job) : 3'b000;
      if (32'(bus.vga_x) != ex)   errs++;
      if (32'(bus.vga_y) != ey)   errs++;
      if (32'(bus.vga_col) != col) errs++;
      if (bus.plot !== ep)        errs++;
      if (dn !== edn)             errs++;
      if (n < w * h - 1 && bus.busy !== 1'b1) errs++;
      if (bus.plot === 1'b1) plots++;
      if (n == 0) begin
        chk({tag, "_first_x"}, 32'(bus.vga_x), 32'(fx));
        chk({tag, "_first_y"}, 32'(bus.vga_y), 32'(fy));
      end
      if (n == w * h - 1) begin
        chk({tag, "_last_x"}, 32'(bus.vga_x), 32'(lx));
        chk({tag, "_last_y"}, 32'(bus.vga_y), 32'(ly));
        chk({tag, "_done"}, 32'(dn), 32'(3'b001 << job));
        case (job)
          0:       bus.clr_req = 1'b0;
          1:       bus.ers_req = 1'b0;
          default: bus.drw_req = 1'b0;
        endcase
      end
    end
    chk({tag, "_pixel_errs"}, 32'(errs), 32'd0);
    if (npix == w * h) chk({tag, "_plots"}, 32'(plots), 32'(exp_plots));
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_plot"}, 32'(bus.plot), 32'd0);
    chk({tag, "_idle_done"}, 32'({bus.drw_done, bus.ers_done, bus.clr_done}), 32'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    drop_vsync  = 1'b0;
    resetn      = 1'b0;
    bus.clr_req = 1'b0;
    bus.ers_req = 1'b0;
    bus.drw_req = 1'b0;
    bus.ers_x   = '0;
    bus.ers_y   = '0;
    bus.drw_x   = '0;
    bus.drw_y   = '0;
    bus.drw_col = '0;
`ifdef FRAME_SYNC_EN
    bus.vsync   = 1'b1;
`else
    bus.vsync   = 1'b0;
`endif

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_plot", 32'(bus.plot), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'({bus.drw_done, bus.ers_done, bus.clr_done}), 32'd0);
    chk("rst_x",    32'(bus.vga_x), 32'd0);
    chk("rst_y",    32'(bus.vga_y), 32'd0);
    chk("rst_col",  32'(bus.vga_col), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_release_busy", 32'(bus.busy), 32'd0);

    // Single draw
    bus.drw_x = 8'd10; bus.drw_y = 7'd20; bus.drw_col = 3'd5; bus.drw_req = 1'b1;
    run_job("draw", 2, 10, 20, 5, 16, 8, 128, 128, 10, 20, 25, 27);
    idle_check("draw");

    // Priority: clear and draw together
    bus.clr_req = 1'b1; bus.drw_req = 1'b1;
    bus.drw_x = 8'd10; bus.drw_y = 7'd20; bus.drw_col = 3'd5;
    run_job("prio_clr", 0, 0, 0, 0, 160, 120, 19200, 19200, 0, 0, 159, 119);
    run_job("prio_drw", 2, 10, 20, 5, 16, 8, 128, 128, 10, 20, 25, 27);
    idle_check("prio");

    // Clipping at the bottom-right corner
    bus.drw_x = 8'd150; bus.drw_y = 7'd115; bus.drw_col = 3'd6; bus.drw_req = 1'b1;
    run_job("clip", 2, 150, 115, 6, 16, 8, 128, 50, 150, 115, 165, 122);
    idle_check("clip");

    // Reset during an erase, then re-issue
    bus.ers_x = 8'd30; bus.ers_y = 7'd40; bus.ers_req = 1'b1;
    run_job("ers_abort", 1, 30, 40, 0, 16, 8, 40, 0, 30, 40, 45, 47);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_plot", 32'(bus.plot), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ers_done", 32'(bus.ers_done), 32'd0);
    resetn = 1'b1;
    run_job("ers_full", 1, 30, 40, 0, 16, 8, 128, 128, 30, 40, 45, 47);
    idle_check("ers");

`ifdef FRAME_SYNC_EN
    // Frame-synchronous grants
    resetn = 1'b0; bus.vsync = 1'b0;
    bus.drw_x = 8'd10; bus.drw_y = 7'd20; bus.drw_col = 3'd5; bus.drw_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("fs_no_vsync_busy", 32'(bus.busy), 32'd0);
    drop_vsync = 1'b1;
    bus.vsync  = 1'b1;
    run_job("fs_job1", 2, 10, 20, 5, 16, 8, 128, 128, 10, 20, 25, 27);
    bus.drw_req = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("fs_wait_busy", 32'(bus.busy), 32'd0);
    bus.vsync = 1'b1;
    run_job("fs_job2", 2, 10, 20, 5, 16, 8, 128, 128, 10, 20, 25, 27);
    idle_check("fs");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
